// File: rtl/npu_pe_pkg.sv
// rtl/npu_pe_pkg.sv - shared NPU compute types: tile FSM states, lane packing, saturating-add helper
package npu_pe_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FEED,
    ST_FLUSH,
    ST_DRAIN,
    ST_DONE
  } tile_state_e;

  // Lane 0 sits in the most significant slot of a packed bus.
  function automatic int lane_base(input int lane, input int lanes, input int width);
    return (lanes - 1 - lane) * width;
  endfunction

  // {positive_overflow, negative_overflow} of a signed add, from the operand and sum sign bits.
  function automatic logic [1:0] add_ovf(input logic sign_a, input logic sign_b, input logic sign_s);
    return {~sign_a & ~sign_b & sign_s, sign_a & sign_b & ~sign_s};
  endfunction

endpackage

// File: rtl/pe_os.sv
// rtl/pe_os.sv - output-stationary PE: operand forwarding registers, step-gated MAC, optional clamp
module pe_os
  import npu_pe_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int WEIGHT_WIDTH = 8,
  parameter int ACC_WIDTH    = 32,
  parameter int SATURATE     = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           clear_i,
  input  logic                           step_i,
  input  logic signed [DATA_WIDTH-1:0]   a_i,
  input  logic signed [WEIGHT_WIDTH-1:0] b_i,
  output logic signed [DATA_WIDTH-1:0]   a_o,
  output logic signed [WEIGHT_WIDTH-1:0] b_o,
  output logic signed [ACC_WIDTH-1:0]    acc_o,
  output logic                           sat_o
);

  localparam int PW = DATA_WIDTH + WEIGHT_WIDTH;

  logic signed [PW-1:0]           prod;
  logic signed [ACC_WIDTH-1:0]    prod_ext, sum, acc_d, acc_q;
  logic signed [DATA_WIDTH-1:0]   a_q;
  logic signed [WEIGHT_WIDTH-1:0] b_q;
  logic [1:0]                     ovf;
  logic                           sat_d, sat_q;

  assign prod     = PW'(a_i) * PW'(b_i);
  assign prod_ext = ACC_WIDTH'(prod);
  assign sum      = acc_q + prod_ext;
  assign ovf      = add_ovf(acc_q[ACC_WIDTH-1], prod_ext[ACC_WIDTH-1], sum[ACC_WIDTH-1]);

  always_comb begin
    acc_d = sum;
    sat_d = sat_q;
    if (SATURATE != 0 && ovf != 2'b00) begin
      acc_d = ovf[1] ? {1'b0, {(ACC_WIDTH-1){1'b1}}} : {1'b1, {(ACC_WIDTH-1){1'b0}}};
      sat_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      sat_q <= 1'b0;
    end else if (step_i) begin
      a_q   <= a_i;
      b_q   <= b_i;
      acc_q <= acc_d;
      sat_q <= sat_d;
    end
  end

  assign a_o   = a_q;
  assign b_o   = b_q;
  assign acc_o = acc_q;
  assign sat_o = sat_q;

endmodule

// File: rtl/pe_array_os.sv
// rtl/pe_array_os.sv - output-stationary systolic MAC array with operand skew and tile controller
module pe_array_os
  import npu_pe_pkg::*;
#(
  parameter int ROWS         = 16,
  parameter int COLS         = 16,
  parameter int DATA_WIDTH   = 8,
  parameter int WEIGHT_WIDTH = 8,
  parameter int ACC_WIDTH    = 32,
  parameter int K_WIDTH      = 16,
  parameter int SATURATE     = 0
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      start,
  input  logic [K_WIDTH-1:0]                        k_len,
  output logic                                      busy,
  output logic                                      done,
  input  logic                                      in_valid,
  output logic                                      in_ready,
  input  logic [ROWS*DATA_WIDTH-1:0]                a_in,
  input  logic [COLS*WEIGHT_WIDTH-1:0]              b_in,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic [COLS*ACC_WIDTH-1:0]                 out_row,
  output logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0] out_row_idx,
  output logic                                      sat_flag
);

  localparam int FLUSH_STEPS = ROWS + COLS - 2;
  localparam int IW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (K_WIDTH > $clog2(ROWS + COLS) + 1) ? K_WIDTH : $clog2(ROWS + COLS) + 1;

  tile_state_e        state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [K_WIDTH-1:0] klen_q, klen_d;
  logic [IW-1:0]      row_q, row_d;
  logic               clear, step, feeding;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    klen_d  = klen_q;
    row_d   = row_q;
    clear   = 1'b0;
    step    = 1'b0;
    case (state_q)
      ST_IDLE: if (start) begin
        klen_d  = k_len;
        clear   = 1'b1;
        cnt_d   = '0;
        state_d = (k_len != '0) ? ST_FEED : ST_DRAIN;
      end
      ST_FEED: if (in_valid) begin
        step = 1'b1;
        if (cnt_q == CW'(klen_q) - CW'(1)) begin
          cnt_d   = '0;
          state_d = (FLUSH_STEPS == 0) ? ST_DRAIN : ST_FLUSH;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_FLUSH: begin
        step = 1'b1;
        if (cnt_q == CW'(FLUSH_STEPS - 1)) begin
          cnt_d   = '0;
          state_d = ST_DRAIN;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DRAIN: if (out_ready) begin
        if (row_q == IW'(ROWS - 1)) begin
          row_d   = '0;
          state_d = ST_DONE;
        end else begin
          row_d = row_q + IW'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      klen_q  <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      klen_q  <= klen_d;
      row_q   <= row_d;
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign in_ready    = (state_q == ST_FEED);
  assign out_valid   = (state_q == ST_DRAIN);
  assign done        = (state_q == ST_DONE);
  assign out_row_idx = row_q;
  assign feeding     = (state_q == ST_FEED);

  // Flush steps inject zeros; lane r/c is delayed r/c steps so operands meet on the anti-diagonal.
  logic signed [DATA_WIDTH-1:0]   a_edge [ROWS];
  logic signed [WEIGHT_WIDTH-1:0] b_edge [COLS];

  for (genvar r = 0; r < ROWS; r++) begin : g_askew
    logic signed [DATA_WIDTH-1:0] lane;
    assign lane = feeding ? a_in[lane_base(r, ROWS, DATA_WIDTH) +: DATA_WIDTH] : '0;
    if (r == 0) begin : g_direct
      assign a_edge[r] = lane;
    end else begin : g_delay
      logic signed [DATA_WIDTH-1:0] sr_q [r];
      always_ff @(posedge clk) begin
        if (rst || clear) begin
          for (int i = 0; i < r; i++) sr_q[i] <= '0;
        end else if (step) begin
          sr_q[0] <= lane;
          for (int i = 1; i < r; i++) sr_q[i] <= sr_q[i-1];
        end
      end
      assign a_edge[r] = sr_q[r-1];
    end
  end

  for (genvar c = 0; c < COLS; c++) begin : g_bskew
    logic signed [WEIGHT_WIDTH-1:0] lane;
    assign lane = feeding ? b_in[lane_base(c, COLS, WEIGHT_WIDTH) +: WEIGHT_WIDTH] : '0;
    if (c == 0) begin : g_direct
      assign b_edge[c] = lane;
    end else begin : g_delay
      logic signed [WEIGHT_WIDTH-1:0] sr_q [c];
      always_ff @(posedge clk) begin
        if (rst || clear) begin
          for (int i = 0; i < c; i++) sr_q[i] <= '0;
        end else if (step) begin
          sr_q[0] <= lane;
          for (int i = 1; i < c; i++) sr_q[i] <= sr_q[i-1];
        end
      end
      assign b_edge[c] = sr_q[c-1];
    end
  end

  logic signed [DATA_WIDTH-1:0]   a_h [ROWS][COLS];
  logic signed [WEIGHT_WIDTH-1:0] b_v [ROWS][COLS];
  logic signed [ACC_WIDTH-1:0]    acc [ROWS][COLS];
  logic [ROWS*COLS-1:0]           pe_sat;

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      logic signed [DATA_WIDTH-1:0]   a_left;
      logic signed [WEIGHT_WIDTH-1:0] b_up;
      if (c == 0) begin : g_a0
        assign a_left = a_edge[r];
      end else begin : g_an
        assign a_left = a_h[r][c-1];
      end
      if (r == 0) begin : g_b0
        assign b_up = b_edge[c];
      end else begin : g_bn
        assign b_up = b_v[r-1][c];
      end
      pe_os #(
        .DATA_WIDTH  (DATA_WIDTH),
        .WEIGHT_WIDTH(WEIGHT_WIDTH),
        .ACC_WIDTH   (ACC_WIDTH),
        .SATURATE    (SATURATE)
      ) u_pe (
        .clk    (clk),
        .rst    (rst),
        .clear_i(clear),
        .step_i (step),
        .a_i    (a_left),
        .b_i    (b_up),
        .a_o    (a_h[r][c]),
        .b_o    (b_v[r][c]),
        .acc_o  (acc[r][c]),
        .sat_o  (pe_sat[r*COLS+c])
      );
    end
    logic unused_a_tail;
    assign unused_a_tail = ^a_h[r][COLS-1];
  end

  for (genvar c = 0; c < COLS; c++) begin : g_btail
    logic unused_b_tail;
    assign unused_b_tail = ^b_v[ROWS-1][c];
  end

  assign sat_flag = |pe_sat;

  always_comb begin
    out_row = '0;
    for (int c = 0; c < COLS; c++) begin
      out_row[lane_base(c, COLS, ACC_WIDTH) +: ACC_WIDTH] = acc[row_q][c];
    end
  end

endmodule

// File: tb/tb_pe_array_os.sv
// tb/tb_pe_array_os.sv - directed bench for pe_array_os (4x4, 16-bit acc, wrap and saturate instances)
module tb_pe_array_os;

  localparam int R  = 4;
  localparam int C  = 4;
  localparam int DW = 8;
  localparam int WW = 8;
  localparam int AW = 16;
  localparam int KW = 16;

  logic            clk = 1'b0;
  logic            rst, start, in_valid, out_ready;
  logic [KW-1:0]   k_len;
  logic [R*DW-1:0] a_in;
  logic [C*WW-1:0] b_in;

  logic            busy0, done0, in_ready0, out_valid0, sat0;
  logic            busy1, done1, in_ready1, out_valid1, sat1;
  logic [C*AW-1:0] row0, row1;
  logic [1:0]      idx0, idx1;

  int              av [8][4];
  int              bv [8][4];
  logic [15:0]     exp0 [4][4];
  logic [15:0]     exp1 [4][4];
  logic            esat;
  int              n_cmp = 0;
  int              n_bad = 0;

  always #5 clk = ~clk;

  pe_array_os #(
    .ROWS(R), .COLS(C), .DATA_WIDTH(DW), .WEIGHT_WIDTH(WW),
    .ACC_WIDTH(AW), .K_WIDTH(KW), .SATURATE(0)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len), .busy(busy0), .done(done0),
    .in_valid(in_valid), .in_ready(in_ready0), .a_in(a_in), .b_in(b_in),
    .out_valid(out_valid0), .out_ready(out_ready), .out_row(row0),
    .out_row_idx(idx0), .sat_flag(sat0)
  );

  pe_array_os #(
    .ROWS(R), .COLS(C), .DATA_WIDTH(DW), .WEIGHT_WIDTH(WW),
    .ACC_WIDTH(AW), .K_WIDTH(KW), .SATURATE(1)
  ) dut_sat (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len), .busy(busy1), .done(done1),
    .in_valid(in_valid), .in_ready(in_ready1), .a_in(a_in), .b_in(b_in),
    .out_valid(out_valid1), .out_ready(out_ready), .out_row(row1),
    .out_row_idx(idx1), .sat_flag(sat1)
  );

  task automatic compute_expected(input int k);
    int s0, s1, p;
    esat = 1'b0;
    for (int r = 0; r < R; r++) begin
      for (int c = 0; c < C; c++) begin
        s0 = 0;
        s1 = 0;
        for (int i = 0; i < k; i++) begin
          p  = av[i][r] * bv[i][c];
          s0 = s0 + p;
          s1 = s1 + p;
          if (s1 > 32767) begin
            s1 = 32767;
            esat = 1'b1;
          end else if (s1 < -32768) begin
            s1 = -32768;
            esat = 1'b1;
          end
        end
        exp0[r][c] = s0[15:0];
        exp1[r][c] = s1[15:0];
      end
    end
  endtask

  function automatic logic [C*AW-1:0] pack_exp(input int r, input bit use_sat);
    logic [C*AW-1:0] v;
    for (int c = 0; c < C; c++) v[(C-1-c)*AW +: AW] = use_sat ? exp1[r][c] : exp0[r][c];
    return v;
  endfunction

  task automatic drain(input int stall_row);
    int holds;
    for (int r = 0; r < R; r++) begin
      holds = (r == stall_row) ? 5 : 0;
      for (int h = 0; h <= holds; h++) begin
        out_ready = (h == holds);
        n_cmp++;
        if ({out_valid0, idx0, done0, in_ready0} !== {1'b1, 2'(r), 1'b0, 1'b0}) begin
          n_bad++;
          $display("FAIL drain_ctrl row %0d hold %0d: valid/idx/done/in_ready got %b want %b",
                   r, h, {out_valid0, idx0, done0, in_ready0}, {1'b1, 2'(r), 1'b0, 1'b0});
        end
        n_cmp++;
        if (row0 !== pack_exp(r, 1'b0)) begin
          n_bad++;
          $display("FAIL wrap_row %0d hold %0d: got %h want %h", r, h, row0, pack_exp(r, 1'b0));
        end
        n_cmp++;
        if (row1 !== pack_exp(r, 1'b1)) begin
          n_bad++;
          $display("FAIL sat_row %0d hold %0d: got %h want %h", r, h, row1, pack_exp(r, 1'b1));
        end
        n_cmp++;
        if ({sat0, sat1, out_valid1, idx1} !== {1'b0, esat, 1'b1, 2'(r)}) begin
          n_bad++;
          $display("FAIL sat_flags row %0d: sat0/sat1/valid1/idx1 got %b want %b",
                   r, {sat0, sat1, out_valid1, idx1}, {1'b0, esat, 1'b1, 2'(r)});
        end
        @(negedge clk);
      end
    end
    n_cmp++;
    if ({done0, done1, out_valid0} !== 3'b110) begin
      n_bad++;
      $display("FAIL done_pulse: done0/done1/out_valid got %b want 110", {done0, done1, out_valid0});
    end
    @(negedge clk);
    n_cmp++;
    if ({done0, busy0, busy1} !== 3'b000) begin
      n_bad++;
      $display("FAIL back_to_idle: done/busy0/busy1 got %b want 000", {done0, busy0, busy1});
    end
  endtask

  task automatic run_tile(input int k, input bit gaps, input int stall_row);
    int edges, guard, exp_lat;
    compute_expected(k);
    start = 1'b1;
    k_len = KW'(k);
    @(negedge clk);
    start = 1'b0;
    k_len = 16'h00ff;
    edges = 0;
    n_cmp++;
    if ({busy0, in_ready0} !== {1'b1, k != 0}) begin
      n_bad++;
      $display("FAIL start_ack: busy/in_ready got %b want %b", {busy0, in_ready0}, {1'b1, k != 0});
    end
    for (int i = 0; i < k; i++) begin
      if (gaps && (i % 2 == 1)) begin
        in_valid = 1'b0;
        a_in = $urandom;
        b_in = $urandom;
        @(negedge clk);
        edges++;
      end
      in_valid = 1'b1;
      for (int r = 0; r < R; r++) a_in[(R-1-r)*DW +: DW] = 8'(av[i][r]);
      for (int c = 0; c < C; c++) b_in[(C-1-c)*WW +: WW] = 8'(bv[i][c]);
      n_cmp++;
      if (in_ready0 !== 1'b1) begin
        n_bad++;
        $display("FAIL feed_ready beat %0d: got %b want 1", i, in_ready0);
      end
      @(negedge clk);
      edges++;
    end
    in_valid = 1'b0;
    guard = 0;
    while (out_valid0 !== 1'b1 && guard < 100) begin
      @(negedge clk);
      edges++;
      guard++;
    end
    n_cmp++;
    if (out_valid0 !== 1'b1) begin
      n_bad++;
      $display("FAIL drain_timeout: out_valid got %b want 1", out_valid0);
    end
    if (!gaps) begin
      exp_lat = (k == 0) ? 1 : k + 7;
      n_cmp++;
      if (edges + 1 != exp_lat) begin
        n_bad++;
        $display("FAIL latency k=%0d: got %0d want %0d", k, edges + 1, exp_lat);
      end
    end
    drain(stall_row);
  endtask

  task automatic test_reset();
    n_cmp++;
    if ({busy0, done0, in_ready0, out_valid0, idx0, sat0, row0} !== '0 ||
        {busy1, done1, in_ready1, out_valid1, idx1, sat1, row1} !== '0) begin
      n_bad++;
      $display("FAIL reset_state: dut %h sat_dut %h want 0",
               {busy0, done0, in_ready0, out_valid0, idx0, sat0, row0},
               {busy1, done1, in_ready1, out_valid1, idx1, sat1, row1});
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({busy0, in_ready0, out_valid0} !== 3'b000) begin
      n_bad++;
      $display("FAIL idle_after_reset: busy/in_ready/out_valid got %b want 000",
               {busy0, in_ready0, out_valid0});
    end
  endtask

  task automatic test_basic();
    for (int r = 0; r < R; r++) av[0][r] = r + 1;
    for (int c = 0; c < C; c++) bv[0][c] = 1;
    run_tile(1, 1'b0, -1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 4; j++) begin
        av[i][j] = int'($urandom_range(255)) - 128;
        bv[i][j] = int'($urandom_range(255)) - 128;
      end
    end
    run_tile(8, 1'b1, -1);
  endtask

  task automatic test_k_zero();
    run_tile(0, 1'b0, -1);
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        av[i][j] = 127;
        bv[i][j] = 127;
      end
    end
    run_tile(4, 1'b0, -1);
  endtask

  task automatic test_stall();
    av[0] = '{1, -2, 3, -4};
    bv[0] = '{2, 3, -1, 5};
    av[1] = '{7, 0, -5, 2};
    bv[1] = '{-3, 4, 6, 1};
    run_tile(2, 1'b0, 2);
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 4; j++) begin
        av[i][j] = 100 - 9 * j - i;
        bv[i][j] = 90 - 7 * i + j;
      end
    end
    start = 1'b1;
    k_len = 16'd8;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      for (int r = 0; r < R; r++) a_in[(R-1-r)*DW +: DW] = 8'(av[i][r]);
      for (int c = 0; c < C; c++) b_in[(C-1-c)*WW +: WW] = 8'(bv[i][c]);
      if (i == 3) rst = 1'b1;
      @(negedge clk);
    end
    rst = 1'b0;
    in_valid = 1'b0;
    n_cmp++;
    if ({busy0, done0, in_ready0, out_valid0, idx0, sat0, row0} !== '0 ||
        {busy1, done1, in_ready1, out_valid1, idx1, sat1, row1} !== '0) begin
      n_bad++;
      $display("FAIL mid_reset_state: dut %h sat_dut %h want 0",
               {busy0, done0, in_ready0, out_valid0, idx0, sat0, row0},
               {busy1, done1, in_ready1, out_valid1, idx1, sat1, row1});
    end
    av[0] = '{5, 6, 7, 8};
    bv[0] = '{1, 2, 3, 4};
    run_tile(1, 1'b0, -1);
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    k_len     = '0;
    a_in      = '0;
    b_in      = '0;
    repeat (3) @(negedge clk);
    test_reset();
    test_basic();
    test_random();
    test_k_zero();
    test_saturate();
    test_stall();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1);
  end

endmodule
